// File: rtl/wb_burst_bridge_if.sv
// Byte-stream and Wishbone signal bundle for wb_burst_bridge.
// Streams: a byte moves only in a cycle where tvalid and tready are both high; the sender holds tdata/tvalid until then.
interface wb_burst_bridge_if #(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32
);
   logic [7:0]           S_axis_tdata;
   logic                 S_axis_tvalid;
   logic                 S_axis_tready;
   logic [7:0]           M_axis_tdata;
   logic                 M_axis_tvalid;
   logic                 M_axis_tready;
   logic [ADDR_SIZE-1:0] M_wb_addr;
   logic                 M_wb_cs;
   logic                 M_wb_we;
   logic [WORD_SIZE-1:0] M_wb_wdata;
   logic [WORD_SIZE-1:0] M_wb_rdata;
   logic                 M_wb_ack;
   logic [2:0]           dbg_state;

   modport master (
      input  S_axis_tdata, S_axis_tvalid,
      output S_axis_tready,
      output M_axis_tdata, M_axis_tvalid,
      input  M_axis_tready,
      output M_wb_addr, M_wb_cs, M_wb_we, M_wb_wdata,
      input  M_wb_rdata, M_wb_ack,
      output dbg_state
   );

   modport slave (
      output S_axis_tdata, S_axis_tvalid,
      input  S_axis_tready,
      input  M_axis_tdata, M_axis_tvalid,
      output M_axis_tready,
      input  M_wb_addr, M_wb_cs, M_wb_we, M_wb_wdata,
      output M_wb_rdata, M_wb_ack,
      input  dbg_state
   );
endinterface

// File: rtl/wb_burst_bridge.sv
// UART-byte command parser driving Wishbone burst reads/writes, with
// per-beat ack timeout, interrupt/reset-request commands and a status byte.
module wb_burst_bridge #(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic              Clk,
   input  logic              Rst,
   wb_burst_bridge_if.master bus,
   output logic              Irq,
   output logic              Req_rst
);

   localparam int AB   = ADDR_SIZE / 8;
   localparam int WB   = WORD_SIZE / 8;
   localparam int MAXB = (AB > WB) ? AB : WB;
   localparam int BCW  = $clog2(MAXB + 1);
   localparam int TCW  = $clog2(TIMEOUT + 1);
   localparam int DCW  = $clog2(256 * WB + 1);

   localparam logic [7:0] CMD_READ   = 8'h01;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_IRQ    = 8'h03;
   localparam logic [7:0] CMD_RST    = 8'h04;
   localparam logic [7:0] STATUS_OK  = 8'hA5;
   localparam logic [7:0] STATUS_ERR = 8'hEE;
   localparam logic [7:0] STATUS_TMO = 8'hE7;

   typedef enum logic [2:0] {
      IDLE, GET_LEN, GET_ADDR, GET_WDATA, BUS, SEND_RDATA, DRAIN, SEND_STATUS
   } state_t;

   state_t               state, state_next;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic [WORD_SIZE-1:0] rdata_q;
   logic                 we_q;
   logic [7:0]           len_q;
   logic [7:0]           beat_idx;
   logic [BCW-1:0]       byte_cnt;
   logic [TCW-1:0]       tcnt;
   logic [DCW-1:0]       drain_cnt;
   logic [7:0]           status_q;
   logic                 tready_q;
   logic                 status_load;
   logic [7:0]           status_next;

   logic s_fire, m_fire, addr_last, word_last, beat_last, tcnt_max, len_too_big;

   assign s_fire      = bus.S_axis_tvalid & bus.S_axis_tready;
   assign m_fire      = bus.M_axis_tvalid & bus.M_axis_tready;
   assign addr_last   = (byte_cnt == BCW'(AB - 1));
   assign word_last   = (byte_cnt == BCW'(WB - 1));
   assign beat_last   = (beat_idx == len_q);
   assign tcnt_max    = (tcnt == TCW'(TIMEOUT - 1));
   assign len_too_big = (({1'b0, bus.S_axis_tdata} + 9'd1) > 9'(MAX_BURST));

   function automatic logic accepts(input state_t s);
      return (s == IDLE) || (s == GET_LEN) || (s == GET_ADDR) ||
             (s == GET_WDATA) || (s == DRAIN);
   endfunction

   always_ff @(posedge Clk) begin
      if (!Rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next  = state;
      status_load = 1'b0;
      status_next = STATUS_OK;
      case (state)
         IDLE: begin
            if (s_fire) begin
               case (bus.S_axis_tdata)
                  CMD_READ, CMD_WRITE: state_next = GET_LEN;
                  CMD_IRQ, CMD_RST: begin
                     state_next  = SEND_STATUS;
                     status_load = 1'b1;
                  end
                  default: begin
                     state_next  = SEND_STATUS;
                     status_load = 1'b1;
                     status_next = STATUS_ERR;
                  end
               endcase
            end
         end
         GET_LEN: begin
            if (s_fire) begin
               if (len_too_big) begin
                  state_next  = SEND_STATUS;
                  status_load = 1'b1;
                  status_next = STATUS_ERR;
               end else begin
                  state_next = GET_ADDR;
               end
            end
         end
         GET_ADDR: begin
            if (s_fire && addr_last) state_next = we_q ? GET_WDATA : BUS;
         end
         GET_WDATA: begin
            if (s_fire && word_last) state_next = BUS;
         end
         BUS: begin
            // Ack wins over a simultaneous timeout.
            if (bus.M_wb_ack) begin
               if (!we_q) begin
                  state_next = SEND_RDATA;
               end else if (beat_last) begin
                  state_next  = SEND_STATUS;
                  status_load = 1'b1;
               end else begin
                  state_next = GET_WDATA;
               end
            end else if (tcnt_max) begin
               status_load = 1'b1;
               status_next = STATUS_TMO;
               state_next  = (we_q && !beat_last) ? DRAIN : SEND_STATUS;
            end
         end
         SEND_RDATA: begin
            if (m_fire && word_last) begin
               if (beat_last) begin
                  state_next  = SEND_STATUS;
                  status_load = 1'b1;
               end else begin
                  state_next = BUS;
               end
            end
         end
         DRAIN: begin
            if (s_fire && drain_cnt == DCW'(1)) state_next = SEND_STATUS;
         end
         SEND_STATUS: begin
            if (m_fire) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         len_q     <= '0;
         beat_idx  <= '0;
         byte_cnt  <= '0;
         tcnt      <= '0;
         drain_cnt <= '0;
         status_q  <= '0;
         tready_q  <= 1'b0;
         Irq       <= 1'b0;
         Req_rst   <= 1'b0;
      end else begin
         tready_q <= accepts(state_next);
         Irq      <= (state == IDLE) && s_fire && (bus.S_axis_tdata == CMD_IRQ);
         Req_rst  <= (state == IDLE) && s_fire && (bus.S_axis_tdata == CMD_RST);
         if (status_load) status_q <= status_next;
         // The timeout count restarts on every entry to BUS.
         tcnt <= (state == BUS && state_next == BUS) ? tcnt + TCW'(1) : '0;
         if (state_next != state)
            byte_cnt <= '0;
         else if ((s_fire && (state == GET_ADDR || state == GET_WDATA)) ||
                  (m_fire && state == SEND_RDATA))
            byte_cnt <= byte_cnt + BCW'(1);

         case (state)
            IDLE: begin
               if (s_fire) we_q <= (bus.S_axis_tdata == CMD_WRITE);
            end
            GET_LEN: begin
               if (s_fire) begin
                  len_q    <= bus.S_axis_tdata;
                  beat_idx <= '0;
               end
            end
            GET_ADDR: begin
               if (s_fire) addr_q <= (addr_q << 8) | ADDR_SIZE'(bus.S_axis_tdata);
            end
            GET_WDATA: begin
               if (s_fire) wdata_q <= (wdata_q << 8) | WORD_SIZE'(bus.S_axis_tdata);
            end
            BUS: begin
               if (bus.M_wb_ack) begin
                  addr_q <= addr_q + ADDR_SIZE'(WB);
                  if (!we_q)           rdata_q  <= bus.M_wb_rdata;
                  else if (!beat_last) beat_idx <= beat_idx + 8'd1;
               end else if (tcnt_max) begin
                  // Write bytes still owed by the host for the beats not yet run.
                  drain_cnt <= DCW'(len_q - beat_idx) * DCW'(WB);
               end
            end
            SEND_RDATA: begin
               if (m_fire) begin
                  rdata_q <= rdata_q << 8;
                  if (word_last && !beat_last) beat_idx <= beat_idx + 8'd1;
               end
            end
            DRAIN: begin
               if (s_fire) drain_cnt <= drain_cnt - DCW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.S_axis_tready = tready_q;
   assign bus.M_axis_tvalid = (state == SEND_RDATA) || (state == SEND_STATUS);
   assign bus.M_axis_tdata  = (state == SEND_STATUS) ? status_q :
                              (state == SEND_RDATA)  ? rdata_q[WORD_SIZE-1 -: 8] : 8'h00;
   assign bus.M_wb_cs       = (state == BUS);
   assign bus.M_wb_addr     = addr_q;
   assign bus.M_wb_we       = we_q;
   assign bus.M_wb_wdata    = wdata_q;
   assign bus.dbg_state     = state;

endmodule

// File: tb/tb_wb_burst_bridge.sv
// Directed and randomized request sequences against a request-level model of
// the bridge: expected response bytes and bus beats are derived per request.
module tb_wb_burst_bridge;
   localparam int AS = 32;
   localparam int WS = 32;
   localparam int MB = 16;
   localparam int TO = 255;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   logic Irq, Req_rst;

   wb_burst_bridge_if #(.ADDR_SIZE(AS), .WORD_SIZE(WS)) bus ();

   wb_burst_bridge #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst), .bus(bus), .Irq(Irq), .Req_rst(Req_rst)
   );

   // clock / watchdog
   always #5 Clk = ~Clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [31:0] exp_addr_q[$];
   logic        exp_we_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] log_addr[$];
   logic        log_we[$];
   logic [31:0] log_data[$];
   int          plan_q[$];
   logic [31:0] rd_vals[$];
   logic [31:0] beat_data [0:255];
   int          beat_delay [0:255];
   int          cs_cycles, irq_cycles, rr_cycles;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // response sink with random back-pressure
   initial begin
      bus.M_axis_tready = 1'b0;
      forever begin
         @(posedge Clk); #1;
         bus.M_axis_tready = ($urandom_range(0, 3) != 0);
         @(negedge Clk);
         if (bus.M_axis_tvalid === 1'b1 && bus.M_axis_tready) got_q.push_back(bus.M_axis_tdata);
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         if (Irq === 1'b1) irq_cycles++;
         if (Req_rst === 1'b1) rr_cycles++;
      end
   end

   // Wishbone slave: each beat takes its ack delay from plan_q; -1 withholds ack
   initial begin
      int wait_n;
      int cur_delay;
      bit in_beat;
      bus.M_wb_ack = 1'b0;
      bus.M_wb_rdata = '0;
      in_beat = 1'b0;
      wait_n = 0;
      cur_delay = -1;
      forever begin
         @(negedge Clk);
         if (bus.M_wb_cs !== 1'b1) begin
            bus.M_wb_ack = 1'b0;
            in_beat = 1'b0;
         end else begin
            cs_cycles++;
            if (!in_beat) begin
               in_beat = 1'b1;
               wait_n = 0;
               if (plan_q.size() > 0) cur_delay = plan_q.pop_front();
               else cur_delay = -1;
            end
            if (cur_delay >= 0 && wait_n == cur_delay) begin
               bus.M_wb_ack = 1'b1;
               log_addr.push_back(bus.M_wb_addr);
               log_we.push_back(bus.M_wb_we);
               if (bus.M_wb_we) begin
                  log_data.push_back(bus.M_wb_wdata);
               end else begin
                  if (rd_vals.size() > 0) bus.M_wb_rdata = rd_vals.pop_front();
                  else bus.M_wb_rdata = 32'h0;
                  log_data.push_back(bus.M_wb_rdata);
               end
            end else begin
               bus.M_wb_ack = 1'b0;
            end
            wait_n++;
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.S_axis_tdata = b;
      bus.S_axis_tvalid = 1'b1;
      forever begin
         @(negedge Clk);
         if (bus.S_axis_tready === 1'b1) break;
         n++;
         if (n > 2000) begin
            check("send_ready", {63'd0, bus.S_axis_tready}, 64'd1);
            break;
         end
      end
      @(posedge Clk); #1;
      bus.S_axis_tvalid = 1'b0;
   endtask

   task automatic finish_req(input string tag);
      int n;
      logic [7:0] g;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 4000) begin
         @(negedge Clk);
         n++;
      end
      repeat (4) @(negedge Clk);
      check({tag, " resp_len"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         if (got_q.size() > 0) g = got_q.pop_front();
         else g = 8'hxx;
         check({tag, " resp_byte"}, g, exp_q.pop_front());
      end
      check({tag, " bus_beats"}, log_addr.size(), exp_addr_q.size());
      while (exp_addr_q.size() > 0 && log_addr.size() > 0) begin
         check({tag, " bus_addr"}, log_addr.pop_front(), exp_addr_q.pop_front());
         check({tag, " bus_we"}, log_we.pop_front(), exp_we_q.pop_front());
         check({tag, " bus_data"}, log_data.pop_front(), exp_data_q.pop_front());
      end
      exp_q.delete(); got_q.delete();
      exp_addr_q.delete(); exp_we_q.delete(); exp_data_q.delete();
      log_addr.delete(); log_we.delete(); log_data.delete();
      plan_q.delete(); rd_vals.delete();
      @(posedge Clk); #1;
   endtask

   // Reference model: beat i hits addr+4i; the first withheld ack ends the burst with E7.
   task automatic run_rw(input bit wr, input int len, input logic [31:0] addr, input string tag);
      logic [7:0] status;
      status = 8'hA5;
      for (int i = 0; i <= len; i++) plan_q.push_back(beat_delay[i]);
      for (int i = 0; i <= len; i++) begin
         if (beat_delay[i] < 0) begin
            status = 8'hE7;
            break;
         end
         exp_addr_q.push_back(addr + 32'(4 * i));
         exp_we_q.push_back(wr);
         exp_data_q.push_back(beat_data[i]);
         if (!wr) begin
            rd_vals.push_back(beat_data[i]);
            for (int k = 3; k >= 0; k--) exp_q.push_back(beat_data[i][8*k +: 8]);
         end
      end
      exp_q.push_back(status);
      send_byte(wr ? 8'h02 : 8'h01);
      send_byte(8'(len));
      for (int k = 3; k >= 0; k--) send_byte(addr[8*k +: 8]);
      if (wr) begin
         for (int i = 0; i <= len; i++)
            for (int k = 3; k >= 0; k--) send_byte(beat_data[i][8*k +: 8]);
      end
      finish_req(tag);
   endtask

   task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] status, input string tag);
      exp_q.push_back(status);
      send_byte(cmd);
      finish_req(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " cs"}, bus.M_wb_cs, 1'b0);
      check({tag, " we"}, bus.M_wb_we, 1'b0);
      check({tag, " m_tvalid"}, bus.M_axis_tvalid, 1'b0);
      check({tag, " irq"}, Irq, 1'b0);
      check({tag, " req_rst"}, Req_rst, 1'b0);
      check({tag, " s_tready"}, bus.S_axis_tready, 1'b0);
      check({tag, " addr"}, bus.M_wb_addr, 32'h0);
      check({tag, " wdata"}, bus.M_wb_wdata, 32'h0);
      check({tag, " m_tdata"}, bus.M_axis_tdata, 8'h00);
   endtask

   task automatic set_beats(input int n, input int delay);
      for (int i = 0; i < n; i++) begin
         beat_data[i] = $urandom;
         beat_delay[i] = delay;
      end
   endtask

   // directed steps, then random requests
   initial begin
      bus.S_axis_tdata = 8'h00;
      bus.S_axis_tvalid = 1'b0;
      cs_cycles = 0; irq_cycles = 0; rr_cycles = 0;
      Rst = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check_reset_outputs("reset");
      @(posedge Clk); #1;
      Rst = 1'b1;
      repeat (2) @(posedge Clk); #1;
      got_q.delete();

      // single write, ack after 3 cycles
      beat_data[0] = 32'hDEADBEEF; beat_delay[0] = 3;
      run_rw(1'b1, 0, 32'h0000_0010, "write1");

      // three-beat read
      beat_data[0] = 32'h1; beat_data[1] = 32'h2; beat_data[2] = 32'h3;
      beat_delay[0] = 1; beat_delay[1] = 0; beat_delay[2] = 2;
      run_rw(1'b0, 2, 32'h0000_0020, "read3");

      // read with no ack: cs held for exactly TIMEOUT cycles
      cs_cycles = 0;
      beat_data[0] = 32'h0; beat_delay[0] = -1;
      run_rw(1'b0, 0, 32'h0000_0000, "read_tmo");
      check("read_tmo cs_cycles", cs_cycles, TO);

      // ack in the last allowed cycle still succeeds
      cs_cycles = 0;
      beat_data[0] = 32'hCAFE_F00D; beat_delay[0] = TO - 1;
      run_rw(1'b0, 0, 32'h0000_0100, "read_late_ack");
      check("read_late_ack cs_cycles", cs_cycles, TO);

      // write timeout on beat 0 drains beat-1 bytes, then Irq command
      set_beats(2, 0);
      beat_delay[0] = -1;
      run_rw(1'b1, 1, 32'h0000_0040, "write_tmo");
      irq_cycles = 0; rr_cycles = 0;
      run_cmd(8'h03, 8'hA5, "irq");
      check("irq pulse", irq_cycles, 1);
      check("irq no req_rst", rr_cycles, 0);

      // over-long burst and unknown command: EE, no bus activity
      cs_cycles = 0;
      exp_q.push_back(8'hEE);
      send_byte(8'h01);
      send_byte(8'h10);
      finish_req("len_too_big");
      run_cmd(8'h7F, 8'hEE, "bad_cmd");
      check("error cmds cs_cycles", cs_cycles, 0);

      // MAX_BURST beats is accepted
      set_beats(MB, 0);
      run_rw(1'b1, MB - 1, 32'h0000_1000, "write_max");

      // address wraps modulo 2^ADDR_SIZE
      set_beats(2, 1);
      run_rw(1'b0, 1, 32'hFFFF_FFFC, "read_wrap");

      for (int it = 0; it < 12; it++) begin
         bit wr;
         int len;
         wr = 1'($urandom_range(0, 1));
         len = $urandom_range(0, 4);
         for (int i = 0; i <= len; i++) begin
            beat_data[i] = $urandom;
            beat_delay[i] = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
         end
         run_rw(wr, len, $urandom, "random");
      end

      // reset in the middle of a write's data phase
      send_byte(8'h02);
      send_byte(8'h00);
      for (int k = 0; k < 4; k++) send_byte(8'h11);
      send_byte(8'hAB);
      send_byte(8'hCD);
      Rst = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      check_reset_outputs("mid_reset");
      @(posedge Clk); #1;
      Rst = 1'b1;
      repeat (2) @(posedge Clk); #1;
      got_q.delete();
      log_addr.delete(); log_we.delete(); log_data.delete();
      irq_cycles = 0; rr_cycles = 0;
      run_cmd(8'h04, 8'hA5, "req_rst");
      check("req_rst pulse", rr_cycles, 1);
      check("req_rst no irq", irq_cycles, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
